// File: rtl/cu_interrupt_sequencer.sv
// Interrupt controller: IE/IF/IME state, EI delay and
// fixed multi-M-cycle dispatch sequencer with vector output.
module cu_interrupt_sequencer #(
  parameter int          NUM_IRQ       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int          VECTOR_STRIDE = 8,
  parameter int          T_PER_M       = 4,
  parameter int          DISPATCH_M    = 5
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Enable,
  input  logic [NUM_IRQ-1:0]    i_Irq_Request,
  input  logic                  i_IE_Write,
  input  logic                  i_IF_Write,
  input  logic [NUM_IRQ-1:0]    i_Reg_Data,
  output logic [NUM_IRQ-1:0]    o_IE,
  output logic [NUM_IRQ-1:0]    o_IF,
  input  logic                  i_EI,
  input  logic                  i_DI,
  input  logic                  i_RETI,
  input  logic                  i_Instr_Boundary,
  output logic                  o_IME,
  output logic                  o_Wake,
  output logic                  o_Handle_Interrupt,
  output logic [DISPATCH_M-1:0] o_Dispatch_Cycle,
  output logic [T_PER_M-1:0]    o_Dispatch_Step,
  output logic [15:0]           o_Vector
);

  localparam int MW = $clog2(DISPATCH_M);
  localparam int TW = $clog2(T_PER_M);

  typedef enum logic {
    S_IDLE,
    S_DISPATCH
  } state_t;

  state_t              r_State;
  state_t              w_State_Nxt;
  logic [MW-1:0]       r_M;
  logic [MW-1:0]       w_M_Nxt;
  logic [TW-1:0]       r_T;
  logic [TW-1:0]       w_T_Nxt;
  logic [NUM_IRQ-1:0]  r_IE;
  logic [NUM_IRQ-1:0]  r_IF;
  logic                r_IME;
  logic                r_Ei_Pending;
  logic [15:0]         r_Vector;

  logic [NUM_IRQ-1:0]  w_Pend;
  logic [NUM_IRQ-1:0]  w_Clear;
  logic [NUM_IRQ-1:0]  w_IF_Nxt;
  logic [2:0]          w_Idx;
  logic                w_Idle;
  logic                w_Accept;
  logic                w_Xfer;
  logic [15:0]         w_Vector;

  assign w_Pend   = r_IE & r_IF;
  assign w_Idle   = (r_State == S_IDLE);
  assign w_Accept = i_Enable & w_Idle & i_Instr_Boundary
                  & r_IME & (|w_Pend);
  // EI takes effect on a later boundary only, so the
  // registered pending flag is what gets transferred.
  assign w_Xfer   = i_Enable & w_Idle & i_Instr_Boundary
                  & r_Ei_Pending;

  always_comb begin
    w_Idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_Pend[i]) w_Idx = 3'(i);
    end
  end

  always_comb begin
    w_Clear = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_Clear[i] = w_Accept && (w_Idx == 3'(i));
    end
  end

  assign w_Vector = VECTOR_BASE
                  + 16'(w_Idx) * 16'(VECTOR_STRIDE);
  assign w_IF_Nxt = ((i_IF_Write ? i_Reg_Data : r_IF)
                  & ~w_Clear) | i_Irq_Request;

  always_comb begin
    w_State_Nxt = r_State;
    w_M_Nxt     = r_M;
    w_T_Nxt     = r_T;
    if (i_Enable) begin
      unique case (r_State)
        S_IDLE: begin
          if (w_Accept) begin
            w_State_Nxt = S_DISPATCH;
            w_M_Nxt     = '0;
            w_T_Nxt     = '0;
          end
        end
        S_DISPATCH: begin
          if (r_T == TW'(T_PER_M - 1)) begin
            w_T_Nxt = '0;
            if (r_M == MW'(DISPATCH_M - 1)) begin
              w_State_Nxt = S_IDLE;
              w_M_Nxt     = '0;
            end else begin
              w_M_Nxt = r_M + 1'b1;
            end
          end else begin
            w_T_Nxt = r_T + 1'b1;
          end
        end
        default: w_State_Nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State      <= S_IDLE;
      r_M          <= '0;
      r_T          <= '0;
      r_IE         <= '0;
      r_IF         <= '0;
      r_IME        <= 1'b0;
      r_Ei_Pending <= 1'b0;
      r_Vector     <= VECTOR_BASE;
    end else begin
      r_IF <= w_IF_Nxt;
      if (i_Enable) begin
        r_State <= w_State_Nxt;
        r_M     <= w_M_Nxt;
        r_T     <= w_T_Nxt;
        if (i_IE_Write) r_IE <= i_Reg_Data;
        if (w_Accept) r_Vector <= w_Vector;
        if (w_Accept || i_DI) r_IME <= 1'b0;
        else if (i_RETI || w_Xfer) r_IME <= 1'b1;
        if (i_DI) r_Ei_Pending <= 1'b0;
        else if (i_EI) r_Ei_Pending <= 1'b1;
        else if (w_Xfer) r_Ei_Pending <= 1'b0;
      end
    end
  end

  assign o_IE               = r_IE;
  assign o_IF               = r_IF;
  assign o_IME              = r_IME;
  assign o_Wake             = |w_Pend;
  assign o_Handle_Interrupt = (r_State == S_DISPATCH);
  assign o_Vector           = r_Vector;
  assign o_Dispatch_Cycle   = o_Handle_Interrupt
                            ? (DISPATCH_M'(1) << r_M) : '0;
  assign o_Dispatch_Step    = o_Handle_Interrupt
                            ? (T_PER_M'(1) << r_T) : '0;

endmodule

// File: tb/tb_cu_interrupt_sequencer.sv
// Bench for cu_interrupt_sequencer: directed steps plus
// random traffic against a cycle-count reference model.
module tb_cu_interrupt_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst, en, iew, ifw, ei, di, reti, bnd;
  logic [4:0] irq, rd;
  logic [4:0] o_ie, o_if;
  logic       o_ime, o_wake, o_hnd;
  logic [4:0] o_cyc;
  logic [3:0] o_stp;
  logic [15:0] o_vec;

  cu_interrupt_sequencer dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en),
    .i_Irq_Request(irq), .i_IE_Write(iew),
    .i_IF_Write(ifw), .i_Reg_Data(rd),
    .o_IE(o_ie), .o_IF(o_if),
    .i_EI(ei), .i_DI(di), .i_RETI(reti),
    .i_Instr_Boundary(bnd),
    .o_IME(o_ime), .o_Wake(o_wake),
    .o_Handle_Interrupt(o_hnd),
    .o_Dispatch_Cycle(o_cyc),
    .o_Dispatch_Step(o_stp),
    .o_Vector(o_vec)
  );

  logic       rst2, iew2, reti2, bnd2;
  logic [7:0] irq2, rd2;
  logic [7:0] o_ie2, o_if2;
  logic       o_ime2, o_wake2, o_hnd2;
  logic [4:0] o_cyc2;
  logic [3:0] o_stp2;
  logic [15:0] o_vec2;

  cu_interrupt_sequencer #(
    .NUM_IRQ(8), .VECTOR_BASE(16'hFFF8)
  ) dut2 (
    .i_Clk(clk), .i_Rst(rst2), .i_Enable(1'b1),
    .i_Irq_Request(irq2), .i_IE_Write(iew2),
    .i_IF_Write(1'b0), .i_Reg_Data(rd2),
    .o_IE(o_ie2), .o_IF(o_if2),
    .i_EI(1'b0), .i_DI(1'b0), .i_RETI(reti2),
    .i_Instr_Boundary(bnd2),
    .o_IME(o_ime2), .o_Wake(o_wake2),
    .o_Handle_Interrupt(o_hnd2),
    .o_Dispatch_Cycle(o_cyc2),
    .o_Dispatch_Step(o_stp2),
    .o_Vector(o_vec2)
  );

  // Reference model: dispatch is tracked as a count of
  // enabled cycles since acceptance, not as m/t counters.
  logic [4:0]  m_ie, m_if;
  logic        m_ime, m_pend, m_busy;
  int          m_cnt;
  logic [15:0] m_vec;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [4:0] pnd;
    logic [4:0] nif;
    logic acc, xfer;
    int idx;
    if (rst) begin
      m_ie = 0; m_if = 0; m_ime = 0; m_pend = 0;
      m_busy = 0; m_cnt = 0; m_vec = 16'h0040;
      return;
    end
    pnd = m_ie & m_if;
    acc = en && !m_busy && bnd && m_ime && (pnd != 0);
    xfer = en && !m_busy && bnd && m_pend;
    idx = 0;
    while (acc && !pnd[idx]) idx++;
    nif = ifw ? rd : m_if;
    if (acc) nif[idx] = 1'b0;
    m_if = nif | irq;
    if (!en) return;
    if (iew) m_ie = rd;
    if (acc || di) m_ime = 0;
    else if (reti || xfer) m_ime = 1;
    if (di) m_pend = 0;
    else if (ei) m_pend = 1;
    else if (xfer) m_pend = 0;
    if (m_busy) begin
      m_cnt++;
      if (m_cnt == 20) begin
        m_busy = 0;
        m_cnt = 0;
      end
    end else if (acc) begin
      m_busy = 1;
      m_cnt = 0;
      m_vec = 16'(16'h0040 + idx * 8);
    end
  endtask

  task automatic tick();
    logic [4:0] ec;
    logic [3:0] es;
    model_step();
    @(posedge clk);
    #1;
    ec = m_busy ? 5'(1 << (m_cnt / 4)) : 5'd0;
    es = m_busy ? 4'(1 << (m_cnt % 4)) : 4'd0;
    chk("IE", o_ie, m_ie);
    chk("IF", o_if, m_if);
    chk("IME", o_ime, m_ime);
    chk("WAKE", o_wake, |(m_ie & m_if));
    chk("HANDLE", o_hnd, m_busy);
    chk("CYCLE", o_cyc, ec);
    chk("STEP", o_stp, es);
    chk("VECTOR", o_vec, m_vec);
  endtask

  task automatic idle_in();
    rst = 0; en = 1; irq = 0; iew = 0; ifw = 0;
    rd = 0; ei = 0; di = 0; reti = 0; bnd = 0;
  endtask

  initial begin
    int n;
    idle_in();
    rst = 1;
    rst2 = 1; iew2 = 0; reti2 = 0; bnd2 = 0;
    irq2 = 0; rd2 = 0;
    tick();
    tick();
    chk("rst_vec", o_vec, 16'h0040);
    chk("rst_hnd", o_hnd, 0);
    chk("rst_wake", o_wake, 0);
    chk("rst_vec2", o_vec2, 16'hFFF8);
    idle_in();

    // single request, full dispatch length
    iew = 1; rd = 5'h1F; tick(); idle_in();
    reti = 1; tick(); idle_in();
    irq = 5'b00100; tick(); idle_in();
    bnd = 1; tick(); idle_in();
    chk("t1_vec", o_vec, 16'h0050);
    chk("t1_if2", o_if[2], 0);
    chk("t1_ime", o_ime, 0);
    n = 0;
    for (int k = 0; k < 26; k++) begin
      if (o_hnd) n++;
      tick();
    end
    chk("t1_len", n, 20);

    // simultaneous requests, priority order
    reti = 1; tick(); idle_in();
    irq = 5'b01010; tick(); idle_in();
    bnd = 1; tick(); idle_in();
    chk("t2_vec1", o_vec, 16'h0048);
    chk("t2_if", o_if, 5'b01000);
    for (int k = 0; k < 20; k++) tick();
    reti = 1; tick(); idle_in();
    bnd = 1; tick(); idle_in();
    chk("t2_vec3", o_vec, 16'h0058);
    for (int k = 0; k < 20; k++) tick();

    // EI delay by one instruction
    irq = 5'b10000; tick(); idle_in();
    ei = 1; bnd = 1; tick(); idle_in();
    chk("t3_ime_n", o_ime, 0);
    for (int k = 0; k < 5; k++) tick();
    chk("t3_ime_n5", o_ime, 0);
    bnd = 1; tick(); idle_in();
    chk("t3_ime_n6", o_ime, 1);
    chk("t3_nohnd", o_hnd, 0);
    bnd = 1; tick(); idle_in();
    chk("t3_hnd", o_hnd, 1);
    chk("t3_vec", o_vec, 16'h0060);
    for (int k = 0; k < 20; k++) tick();

    // wake without IME; EI cancelled by DI
    iew = 1; rd = 5'b10000; tick(); idle_in();
    irq = 5'b10000; tick(); idle_in();
    chk("t4_wake", o_wake, 1);
    bnd = 1; tick(); idle_in();
    chk("t4_nohnd", o_hnd, 0);
    ei = 1; tick(); idle_in();
    di = 1; tick(); idle_in();
    bnd = 1; tick(); tick(); idle_in();
    chk("t4_ime", o_ime, 0);
    ifw = 1; rd = 0; irq = 5'b00001; tick(); idle_in();
    chk("t4_if_req", o_if, 5'b00001);

    // enable stall and reset mid-dispatch
    iew = 1; rd = 5'h1F; tick(); idle_in();
    reti = 1; tick(); idle_in();
    bnd = 1; tick(); idle_in();
    for (int k = 0; k < 8; k++) tick();
    en = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("t5_frz_cyc", o_cyc, 5'b00100);
      chk("t5_frz_stp", o_stp, 4'b0001);
    end
    en = 1;
    for (int k = 0; k < 4; k++) tick();
    chk("t5_m3", o_cyc, 5'b01000);
    rst = 1; tick(); idle_in();
    chk("t5_hnd", o_hnd, 0);
    chk("t5_cyc", o_cyc, 0);
    chk("t5_stp", o_stp, 0);
    chk("t5_ie", o_ie, 0);
    chk("t5_if", o_if, 0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      rst  = ($urandom_range(0, 79) == 0);
      en   = ($urandom_range(0, 7) != 0);
      irq  = 5'($urandom) & 5'($urandom) & 5'($urandom);
      iew  = ($urandom_range(0, 9) == 0);
      ifw  = ($urandom_range(0, 15) == 0);
      rd   = 5'($urandom);
      ei   = ($urandom_range(0, 11) == 0);
      di   = ($urandom_range(0, 23) == 0);
      reti = ($urandom_range(0, 7) == 0);
      bnd  = ($urandom_range(0, 2) == 0);
      tick();
    end
    idle_in();

    // 16-bit vector wrap on the 8-channel instance
    rst2 = 0;
    iew2 = 1; rd2 = 8'hFF; tick(); iew2 = 0;
    reti2 = 1; tick(); reti2 = 0;
    irq2 = 8'h02; tick(); irq2 = 0;
    bnd2 = 1; tick(); bnd2 = 0;
    chk("w_hnd", o_hnd2, 1);
    chk("w_vec", o_vec2, 16'h0000);
    chk("w_if", o_if2, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
